dcache_victim_buffer: RTL and testbench

Small fully-associative victim buffer beside the write-back data cache. It captures lines evicted from the direct-mapped array on a miss and returns them on a victim hit, including a same-cycle swap. Dirty lines it displaces, or drains during a flush, go out through a one-entry write-back holding register toward data memory.

---
 rtl/dcache_victim_buffer.sv | 215 +++++++++++++++++++++
 tb/tb_dcache_victim_buffer.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_victim_buffer.sv
// Fully-associative victim buffer beside the direct-mapped data cache.
// Holds evicted lines, serves victim hits/swaps, and drains dirty lines through a one-entry write-back register.
module dcache_victim_buffer #(
    parameter int VB_ENTRIES  = 4,
    parameter int LINE_ADDR_W = 28,
    parameter int LINE_W      = 128
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [LINE_ADDR_W-1:0] lookup_addr_i,
    input  logic                   lookup_valid_i,
    output logic                   victim_hit_o,
    output logic [LINE_W-1:0]      victim_line_o,
    output logic                   victim_dirty_o,
    input  logic                   write_from_victim_i,
    input  logic                   write_to_victim_i,
    input  logic [LINE_ADDR_W-1:0] evict_addr_i,
    input  logic [LINE_W-1:0]      evict_line_i,
    input  logic                   evict_dirty_i,
    output logic                   insert_ready_o,
    output logic                   wb_valid_o,
    output logic [LINE_ADDR_W-1:0] wb_addr_o,
    output logic [LINE_W-1:0]      wb_line_o,
    input  logic                   wb_ready_i,
    input  logic                   flush_i,
    output logic                   flush_done_o,
    input  logic                   kill_i
);
    localparam int IDX_W = $clog2(VB_ENTRIES);

    typedef enum logic [1:0] {
        VB_IDLE,
        VB_FLUSH_SCAN,
        VB_FLUSH_WAIT,
        VB_FLUSH_DONE
    } vb_state_e;

    vb_state_e state_q, state_d;

    logic [VB_ENTRIES-1:0]  valid_q, valid_d;
    logic [VB_ENTRIES-1:0]  dirty_q, dirty_d;
    logic [LINE_ADDR_W-1:0] addr_q [VB_ENTRIES];
    logic [LINE_ADDR_W-1:0] addr_d [VB_ENTRIES];
    logic [LINE_W-1:0]      line_q [VB_ENTRIES];
    logic [LINE_W-1:0]      line_d [VB_ENTRIES];
    logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]       scan_idx_q, scan_idx_d;
    logic                   wb_valid_q, wb_valid_d;
    logic [LINE_ADDR_W-1:0] wb_addr_q, wb_addr_d;
    logic [LINE_W-1:0]      wb_line_q, wb_line_d;

    logic             hit_any, match_any, free_any;
    logic [IDX_W-1:0] hit_idx, match_idx, free_idx;
    logic             extract_req, merge_dirty, use_rr, displace_dirty, wb_free;
    logic [IDX_W-1:0] slot_idx;
    logic             in_idle, in_scan;
    logic             do_extract, do_insert;
    logic             scan_need, scan_move, scan_adv, scan_last;

    // Associative search; descending loop makes the lowest index win.
    always_comb begin
        hit_any   = 1'b0;
        hit_idx   = '0;
        match_any = 1'b0;
        match_idx = '0;
        free_any  = 1'b0;
        free_idx  = '0;
        for (int i = VB_ENTRIES - 1; i >= 0; i--) begin
            if (valid_q[i] && addr_q[i] == lookup_addr_i) begin
                hit_any = 1'b1;
                hit_idx = IDX_W'(i);
            end
            if (valid_q[i] && addr_q[i] == evict_addr_i) begin
                match_any = 1'b1;
                match_idx = IDX_W'(i);
            end
            if (!valid_q[i]) begin
                free_any = 1'b1;
                free_idx = IDX_W'(i);
            end
        end
    end

    assign victim_hit_o   = !rst && lookup_valid_i && hit_any;
    assign victim_line_o  = victim_hit_o ? line_q[hit_idx] : '0;
    assign victim_dirty_o = victim_hit_o && dirty_q[hit_idx];

    always_comb begin
        merge_dirty = 1'b0;
        use_rr      = 1'b0;
        if (extract_req) begin
            slot_idx = hit_idx;
        end else if (match_any) begin
            slot_idx    = match_idx;
            merge_dirty = 1'b1;
        end else if (free_any) begin
            slot_idx = free_idx;
        end else begin
            slot_idx = rr_ptr_q;
            use_rr   = 1'b1;
        end
    end

    // The buffer is full whenever use_rr is set, so the rr victim is always valid.
    assign extract_req    = write_from_victim_i && victim_hit_o;
    assign displace_dirty = use_rr && dirty_q[rr_ptr_q];
    assign wb_free        = !wb_valid_q || wb_ready_i;
    assign insert_ready_o = rst || !(displace_dirty && !wb_free);

    assign do_extract = in_idle && extract_req;
    assign do_insert  = in_idle && write_to_victim_i && insert_ready_o;

    assign scan_need = valid_q[scan_idx_q] && dirty_q[scan_idx_q];
    assign scan_move = in_scan && !kill_i && scan_need && wb_free;
    assign scan_adv  = in_scan && !kill_i && (!scan_need || wb_free);
    assign scan_last = (scan_idx_q == IDX_W'(VB_ENTRIES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= VB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            VB_IDLE: begin
                if (flush_i) state_d = VB_FLUSH_SCAN;
            end
            VB_FLUSH_SCAN: begin
                if (kill_i) state_d = VB_IDLE;
                else if (scan_adv && scan_last) state_d = VB_FLUSH_WAIT;
            end
            VB_FLUSH_WAIT: begin
                if (kill_i) state_d = VB_IDLE;
                else if (!wb_valid_q) state_d = VB_FLUSH_DONE;
            end
            VB_FLUSH_DONE: state_d = VB_IDLE;
            default: state_d = VB_IDLE;
        endcase
    end

    always_comb begin
        in_idle      = (state_q == VB_IDLE);
        in_scan      = (state_q == VB_FLUSH_SCAN);
        flush_done_o = !rst && (state_q == VB_FLUSH_DONE);
    end

    always_comb begin
        valid_d    = valid_q;
        dirty_d    = dirty_q;
        addr_d     = addr_q;
        line_d     = line_q;
        rr_ptr_d   = rr_ptr_q;
        scan_idx_d = scan_idx_q;
        wb_valid_d = wb_valid_q && !wb_ready_i;
        wb_addr_d  = wb_addr_q;
        wb_line_d  = wb_line_q;

        if (do_extract) valid_d[hit_idx] = 1'b0;

        if (do_insert) begin
            if (displace_dirty) begin
                wb_valid_d = 1'b1;
                wb_addr_d  = addr_q[slot_idx];
                wb_line_d  = line_q[slot_idx];
            end
            valid_d[slot_idx] = 1'b1;
            dirty_d[slot_idx] = merge_dirty ? (dirty_q[slot_idx] | evict_dirty_i) : evict_dirty_i;
            addr_d[slot_idx]  = evict_addr_i;
            line_d[slot_idx]  = evict_line_i;
            if (use_rr) rr_ptr_d = rr_ptr_q + IDX_W'(1);
        end

        if (scan_move) begin
            wb_valid_d          = 1'b1;
            wb_addr_d           = addr_q[scan_idx_q];
            wb_line_d           = line_q[scan_idx_q];
            dirty_d[scan_idx_q] = 1'b0;
        end

        if (scan_adv) scan_idx_d = scan_idx_q + IDX_W'(1);
        if ((!in_idle && kill_i) || (in_idle && flush_i)) scan_idx_d = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q    <= '0;
            dirty_q    <= '0;
            rr_ptr_q   <= '0;
            scan_idx_q <= '0;
            wb_valid_q <= 1'b0;
        end else begin
            valid_q    <= valid_d;
            dirty_q    <= dirty_d;
            rr_ptr_q   <= rr_ptr_d;
            scan_idx_q <= scan_idx_d;
            wb_valid_q <= wb_valid_d;
        end
    end

    // Payload storage is qualified by the valid bits and needs no reset.
    always_ff @(posedge clk) begin
        addr_q    <= addr_d;
        line_q    <= line_d;
        wb_addr_q <= wb_addr_d;
        wb_line_q <= wb_line_d;
    end

    assign wb_valid_o = !rst && wb_valid_q;
    assign wb_addr_o  = wb_valid_o ? wb_addr_q : '0;
    assign wb_line_o  = wb_valid_o ? wb_line_q : '0;
endmodule

// File: tb/tb_dcache_victim_buffer.sv
// Scoreboard bench for dcache_victim_buffer: a high-level entry-table model predicts lookups and write-backs.
module tb_dcache_victim_buffer;
    localparam int N  = 4;
    localparam int AW = 28;
    localparam int LW = 128;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst = 1'b1;
    logic [AW-1:0] lookup_addr_i = '0;
    logic          lookup_valid_i = 1'b0;
    logic          victim_hit_o;
    logic [LW-1:0] victim_line_o;
    logic          victim_dirty_o;
    logic          write_from_victim_i = 1'b0;
    logic          write_to_victim_i = 1'b0;
    logic [AW-1:0] evict_addr_i = '0;
    logic [LW-1:0] evict_line_i = '0;
    logic          evict_dirty_i = 1'b0;
    logic          insert_ready_o;
    logic          wb_valid_o;
    logic [AW-1:0] wb_addr_o;
    logic [LW-1:0] wb_line_o;
    logic          wb_ready_i = 1'b0;
    logic          flush_i = 1'b0;
    logic          flush_done_o;
    logic          kill_i = 1'b0;

    dcache_victim_buffer #(.VB_ENTRIES(N), .LINE_ADDR_W(AW), .LINE_W(LW)) dut (
        .clk(clk), .rst(rst),
        .lookup_addr_i(lookup_addr_i), .lookup_valid_i(lookup_valid_i),
        .victim_hit_o(victim_hit_o), .victim_line_o(victim_line_o), .victim_dirty_o(victim_dirty_o),
        .write_from_victim_i(write_from_victim_i), .write_to_victim_i(write_to_victim_i),
        .evict_addr_i(evict_addr_i), .evict_line_i(evict_line_i), .evict_dirty_i(evict_dirty_i),
        .insert_ready_o(insert_ready_o),
        .wb_valid_o(wb_valid_o), .wb_addr_o(wb_addr_o), .wb_line_o(wb_line_o), .wb_ready_i(wb_ready_i),
        .flush_i(flush_i), .flush_done_o(flush_done_o), .kill_i(kill_i)
    );

    typedef struct {
        bit            chk_ctl;
        logic          hit;
        logic [LW-1:0] line;
        logic          dirty;
        logic          ready;
        logic          wbv;
    } lk_t;
    typedef struct {
        logic [AW-1:0] a;
        logic [LW-1:0] l;
    } wb_t;

    lk_t lkq[$];
    wb_t wbq[$];
    lk_t mon_e;
    wb_t mon_w;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_cnt = 0;
    int done_cyc = 0;

    // Reference model: an unordered table of entries plus round-robin and holding-register occupancy.
    bit            mv [N];
    bit            md [N];
    logic [AW-1:0] ma [N];
    logic [LW-1:0] ml [N];
    int            m_rr = 0;
    bit            m_occ = 1'b0;
    bit            m_flush = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: compares whatever the DUT presents against the queued expectations.
    always @(negedge clk) begin
        if (flush_done_o) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (!rst && lkq.size() > 0) begin
            mon_e = lkq.pop_front();
            chk("victim_hit", victim_hit_o, mon_e.hit);
            chk("victim_line", victim_line_o, mon_e.line);
            chk("victim_dirty", victim_dirty_o, mon_e.dirty);
            if (mon_e.chk_ctl) begin
                chk("insert_ready", insert_ready_o, mon_e.ready);
                chk("wb_valid", wb_valid_o, mon_e.wbv);
            end
        end
        if (wb_valid_o && wb_ready_i) begin
            if (wbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL wb_unexpected: got addr %0h, expected no write-back", wb_addr_o);
            end else begin
                mon_w = wbq.pop_front();
                chk("wb_addr", wb_addr_o, mon_w.a);
                chk("wb_line", wb_line_o, mon_w.l);
            end
        end
    end

    function automatic int find(input logic [AW-1:0] a);
        for (int i = 0; i < N; i++) if (mv[i] && ma[i] == a) return i;
        return -1;
    endfunction

    function automatic int first_free();
        for (int i = 0; i < N; i++) if (!mv[i]) return i;
        return -1;
    endfunction

    task automatic cycle(input bit lv, input logic [AW-1:0] la, input bit wf, input bit wt,
                         input logic [AW-1:0] ea, input logic [LW-1:0] el, input bit ed,
                         input bit wr, input bit fl = 1'b0, input bit kl = 1'b0);
        lk_t e;
        wb_t w;
        int  h, slot, m;
        bit  merge, rrinc, dd, ext, rdy;
        @(posedge clk);
        #1;
        rst = 1'b0;
        lookup_valid_i = lv; lookup_addr_i = la;
        write_from_victim_i = wf; write_to_victim_i = wt;
        evict_addr_i = ea; evict_line_i = el; evict_dirty_i = ed;
        wb_ready_i = wr; flush_i = fl; kill_i = kl;

        h = lv ? find(la) : -1;
        e.chk_ctl = !m_flush;
        e.hit   = (h >= 0);
        e.line  = (h >= 0) ? ml[h] : '0;
        e.dirty = (h >= 0) ? md[h] : 1'b0;
        ext = wf && (h >= 0);
        merge = 0; rrinc = 0; dd = 0;
        m = find(ea);
        if (ext) slot = h;
        else if (m >= 0) begin slot = m; merge = 1; end
        else if (first_free() >= 0) slot = first_free();
        else begin slot = m_rr; rrinc = 1; dd = md[slot]; end
        rdy = !(dd && m_occ && !wr);
        e.ready = rdy;
        e.wbv   = m_occ;
        lkq.push_back(e);

        if (!m_flush) begin
            if (m_occ && wr) m_occ = 0;
            if (ext) mv[h] = 0;
            if (wt && rdy) begin
                if (dd) begin
                    w.a = ma[slot]; w.l = ml[slot];
                    wbq.push_back(w);
                    m_occ = 1;
                end
                md[slot] = merge ? (md[slot] | ed) : ed;
                mv[slot] = 1; ma[slot] = ea; ml[slot] = el;
                if (rrinc) m_rr = (m_rr + 1) % N;
            end
        end
    endtask

    task automatic idle(input bit wr);
        cycle(0, '0, 0, 0, '0, '0, 0, wr);
    endtask

    task automatic ins(input logic [AW-1:0] a, input logic [LW-1:0] l, input bit d, input bit wr);
        cycle(0, '0, 0, 1, a, l, d, wr);
    endtask

    task automatic look(input logic [AW-1:0] a, input bit wf, input bit wr);
        cycle(1, a, wf, 0, '0, '0, 0, wr);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        lookup_valid_i = 1'b1; lookup_addr_i = ma[0];
        write_from_victim_i = 1'b0; write_to_victim_i = 1'b0;
        flush_i = 1'b0; kill_i = 1'b0; wb_ready_i = 1'b0;
        lkq.delete();
        @(posedge clk);
        @(negedge clk);
        chk("rst_hit", victim_hit_o, 0);
        chk("rst_line", victim_line_o, 0);
        chk("rst_dirty", victim_dirty_o, 0);
        chk("rst_ready", insert_ready_o, 1);
        chk("rst_wb_valid", wb_valid_o, 0);
        chk("rst_wb_addr", wb_addr_o, 0);
        chk("rst_wb_line", wb_line_o, 0);
        chk("rst_flush_done", flush_done_o, 0);
        for (int i = 0; i < N; i++) begin mv[i] = 0; md[i] = 0; end
        m_rr = 0; m_occ = 0; m_flush = 0;
        wbq.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        lookup_valid_i = 1'b0;
    endtask

    task automatic run_flush(input bit check_lat);
        wb_t w;
        int  start, d0;
        for (int i = 0; i < N; i++) begin
            if (mv[i] && md[i]) begin
                w.a = ma[i]; w.l = ml[i];
                wbq.push_back(w);
            end
        end
        m_flush = 1;
        d0 = done_cnt;
        cycle(0, '0, 0, 0, '0, '0, 0, 1, 1, 0);
        start = cyc;
        for (int k = 0; k < 40 && done_cnt == d0; k++) idle(1);
        for (int i = 0; i < N; i++) md[i] = 0;
        m_occ = 0;
        m_flush = 0;
        repeat (3) idle(1);
        chk("flush_done_pulses", done_cnt - d0, 1);
        if (check_lat) chk("flush_latency", done_cyc - start, N + 2);
    endtask

    logic [LW-1:0] line_a;

    initial begin
        int d0;
        bit lv, wf, wt, ed, wr;
        logic [AW-1:0] la, ea;
        logic [LW-1:0] el;

        line_a = {$urandom, $urandom, $urandom, $urandom};
        do_reset();

        // Basic insert, hit, extract, miss.
        ins(28'h10, line_a, 0, 1);
        look(28'h10, 1, 1);
        look(28'h10, 0, 1);
        idle(1);

        // Round-robin displacement of a dirty entry and the insert back-pressure.
        do_reset();
        ins(28'h1, {4{$urandom}}, 1, 1);
        ins(28'h2, {4{$urandom}}, 1, 1);
        ins(28'h3, {4{$urandom}}, 0, 1);
        ins(28'h4, {4{$urandom}}, 0, 1);
        ins(28'h5, {4{$urandom}}, 0, 0);
        ins(28'h6, {4{$urandom}}, 0, 0);
        ins(28'h6, {4{$urandom}}, 0, 0);
        ins(28'h6, {4{$urandom}}, 0, 1);
        idle(1);
        look(28'h2, 0, 1);

        // Same-cycle swap keeps the round-robin pointer and displaces nothing.
        cycle(1, 28'h3, 1, 1, 28'h9, {4{$urandom}}, 0, 1);
        look(28'h3, 0, 1);
        look(28'h9, 0, 1);

        // Flush with two dirty entries, then a clean flush for latency.
        ins(28'h4, {4{$urandom}}, 1, 1);
        ins(28'h9, {4{$urandom}}, 1, 1);
        run_flush(0);
        look(28'h4, 0, 1);
        look(28'h9, 0, 1);
        run_flush(1);

        // Kill mid-scan with the holding register loaded and memory stalled.
        ins(28'h5, {4{$urandom}}, 1, 1);
        idle(1);
        begin
            wb_t w;
            w.a = ma[0]; w.l = ml[0];
            wbq.push_back(w);
        end
        m_flush = 1;
        d0 = done_cnt;
        cycle(0, '0, 0, 0, '0, '0, 0, 0, 1, 0);
        idle(0);
        idle(0);
        cycle(0, '0, 0, 0, '0, '0, 0, 0, 0, 1);
        m_flush = 0;
        md[0] = 0;
        m_occ = 1;
        ins(28'h77, {4{$urandom}}, 0, 0);
        look(28'h5, 0, 0);
        idle(0);
        look(28'h77, 0, 1);
        idle(1);
        chk("kill_no_done", done_cnt - d0, 0);

        // Randomized traffic over a small address pool to force hits, merges and displacement.
        for (int it = 0; it < 300; it++) begin
            lv = ($urandom % 4) != 0;
            la = 28'h20 + 28'($urandom % 12);
            wf = ($urandom % 3) == 0;
            wt = ($urandom % 2) == 1;
            ea = 28'h20 + 28'($urandom % 12);
            el = {$urandom, $urandom, $urandom, $urandom};
            ed = ($urandom % 2) == 1;
            wr = ($urandom % 3) != 0;
            if (lv && wf && wt && find(la) >= 0 && find(ea) >= 0 && find(ea) != find(la)) wf = 0;
            cycle(lv, la, wf, wt, ea, el, ed, wr);
        end

        // Reset with a write-back likely pending discards everything.
        for (int i = 0; i < 6; i++) ins(28'h40 + 28'(i), {4{$urandom}}, 1, 0);
        do_reset();
        look(28'h40, 0, 1);
        look(28'h45, 0, 1);
        repeat (3) idle(1);

        chk("wb_queue_drained", wbq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1);
    end
endmodule
